// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave endpoints.
// State encoding, mode encodings and counter sizing.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_DATA_W = 8;

  localparam logic CPOL_LOW   = 1'b0;
  localparam logic CPOL_HIGH  = 1'b1;
  localparam logic CPHA_LEAD  = 1'b0;
  localparam logic CPHA_TRAIL = 1'b1;

  function automatic int bit_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses on the
// synchronized level, for asynchronous SPI pins.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave endpoint: oversampled sclk/ss/mosi, byte-wide
// valid/ready rx and single-entry tx buffer.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = 8'hFF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CW = bit_cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  function automatic logic head(
    input logic [DATA_W-1:0] b,
    input logic              lsb
  );
    return lsb ? b[0] : b[DATA_W-1];
  endfunction

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_ss_q, w_ss_rise, w_ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_d     (sclk),
    .o_q     (w_sclk_q),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_d     (ss),
    .o_q     (w_ss_q),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  spi_state_e        r_state;
  logic              r_cpol, r_cpha, r_lsbfe;
  logic              r_pend;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_tx_sh, r_rx_sh;
  logic [DATA_W-1:0] r_tx_buf, r_rx_data;
  logic              r_tx_full, r_rx_valid;
  logic              r_miso, r_oe, r_busy;
  logic              r_ovr, r_udr;

  logic              w_edge, w_lead, w_trail;
  logic              w_sample, w_shift;
  logic              w_active, w_start, w_load;
  logic              w_tx_wr, w_rx_acc;
  logic [DATA_W-1:0] w_ld_byte, w_tx_adv, w_rx_next;

  // edge class is decided by the level sclk moved to, not its direction
  assign w_edge   = (w_sclk_rise | w_sclk_fall) & ~w_ss_q;
  assign w_lead   = w_edge & (w_sclk_q != r_cpol);
  assign w_trail  = w_edge & (w_sclk_q == r_cpol);
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead : w_trail;

  assign w_active = (r_state == ST_ACTIVE);
  assign w_start  = (r_state == ST_IDLE) & w_ss_fall;
  assign w_load   = (w_start & (cpha == CPHA_LEAD))
                  | (w_active & ~w_ss_rise & w_shift & r_pend);

  assign w_tx_wr   = tx_valid & ~r_tx_full;
  assign w_rx_acc  = r_rx_valid & rx_ready;
  assign w_ld_byte = r_tx_full ? r_tx_buf : IDLE_TX;
  assign w_tx_adv  = r_lsbfe ? (r_tx_sh >> 1) : (r_tx_sh << 1);
  assign w_rx_next = r_lsbfe ? {w_mosi, r_rx_sh[DATA_W-1:1]}
                             : {r_rx_sh[DATA_W-2:0], w_mosi};

  // a load in the same cycle as a write takes the old contents
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
      r_udr     <= 1'b0;
    end else begin
      r_udr     <= w_load & ~r_tx_full;
      r_tx_full <= w_tx_wr | (r_tx_full & ~w_load);
      if (w_tx_wr) r_tx_buf <= tx_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      r_cpol     <= CPOL_LOW;
      r_cpha     <= CPHA_LEAD;
      r_lsbfe    <= 1'b0;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_rx_acc) r_rx_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state <= ST_ACTIVE;
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_lsbfe <= lsbfe;
            r_pend  <= cpha;
            if (cpha == CPHA_LEAD) begin
              r_tx_sh <= w_ld_byte;
              r_miso  <= head(w_ld_byte, lsbfe);
            end
          end
        end
        ST_ACTIVE: begin
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
          end else begin
            if (w_shift) begin
              if (r_pend) begin
                r_tx_sh <= w_ld_byte;
                r_miso  <= head(w_ld_byte, r_lsbfe);
                r_pend  <= 1'b0;
              end else begin
                r_tx_sh <= w_tx_adv;
                r_miso  <= head(w_tx_adv, r_lsbfe);
              end
            end
            if (w_sample) begin
              r_rx_sh <= w_rx_next;
              if (r_cnt == LAST) begin
                r_cnt      <= '0;
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_ovr      <= r_rx_valid & ~rx_ready;
                r_pend     <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
        end
      endcase
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = r_oe;
  assign busy        = r_busy;
  assign tx_ready    = ~r_tx_full;
  assign tx_underrun = r_udr;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_ovr;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: behavioural SPI master plus a
// frame-level model of the tx buffer and rx handshake.
module tb_spi_slave_core;

  localparam int T = 10;
  localparam int H = 80;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
  logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, rx_ready = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid;
  logic       rx_overrun, tx_underrun, busy;
  logic [7:0] rx_data;

  int n_chk = 0;
  int n_fail = 0;
  int n_udr = 0;
  int n_ovr = 0;

  spi_slave_core dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsbfe       (lsbfe),
    .sclk        (sclk),
    .ss          (ss),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    #1;
    if (tx_underrun) n_udr = n_udr + 1;
    if (rx_overrun)  n_ovr = n_ovr + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge PCLK);
    while (!tx_ready && t < 400) begin
      @(negedge PCLK);
      t++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
  endtask

  task automatic rx_accept(input string nm);
    @(negedge PCLK);
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    chk({nm, "_rx_valid_clr"}, 32'(rx_valid), 32'd0);
  endtask

  // Plain SPI master; the last frame may be cut short after nbits.
  task automatic spi_xfer(input logic pol, input logic pha,
                          input logic lsb, input int nfr,
                          input int nbits, input logic hold,
                          input logic [7:0] mo [4],
                          output logic [7:0] mi [4]);
    int idx, nb;
    mi = '{default: 8'h00};
    @(negedge PCLK);
    sclk  = pol;
    cpol  = pol;
    cpha  = pha;
    lsbfe = lsb;
    #(4*T);
    ss = 1'b0;
    #H;
    for (int f = 0; f < nfr; f++) begin
      nb = (f == nfr - 1) ? nbits : 8;
      for (int b = 0; b < nb; b++) begin
        idx = lsb ? b : 7 - b;
        if (!pha) begin
          mosi = mo[f][idx];
          #H; sclk = ~pol; mi[f][idx] = miso;
          #H; sclk = pol;
        end else begin
          #H; sclk = ~pol; mosi = mo[f][idx];
          #H; sclk = pol; mi[f][idx] = miso;
        end
      end
    end
    #H;
    if (!hold) ss = 1'b1;
    #(8*T);
  endtask

  // Model: each frame's byte is whatever the buffer holds at its load;
  // cpha=0 loads at ss fall and after every frame, cpha=1 at each frame start.
  task automatic run_case(input string nm, input logic pol,
                          input logic pha, input logic lsb,
                          input int nfr, input logic [7:0] mo [4],
                          input logic pre, input logic [7:0] pre_b);
    logic [7:0] mi [4];
    logic [7:0] exp_mi [4];
    logic [7:0] q [$];
    logic [7:0] b;
    int u0, o0, eu, nl;
    exp_mi = '{default: 8'h00};
    if (pre) begin
      tx_write(pre_b);
      q.push_back(pre_b);
      chk({nm, "_tx_full"}, 32'(tx_ready), 32'd0);
    end
    u0 = n_udr;
    o0 = n_ovr;
    spi_xfer(pol, pha, lsb, nfr, 8, 1'b0, mo, mi);
    nl = nfr + (pha ? 0 : 1);
    eu = 0;
    for (int l = 0; l < nl; l++) begin
      if (q.size() > 0) b = q.pop_front();
      else begin
        b = 8'hFF;
        eu++;
      end
      if (l < nfr) exp_mi[l] = b;
    end
    for (int f = 0; f < nfr; f++)
      chk({nm, "_miso_byte"}, 32'(mi[f]), 32'(exp_mi[f]));
    chk({nm, "_rx_data"}, 32'(rx_data), 32'(mo[nfr-1]));
    chk({nm, "_rx_valid"}, 32'(rx_valid), 32'd1);
    chk({nm, "_overruns"}, 32'(n_ovr - o0), 32'(nfr - 1));
    chk({nm, "_underruns"}, 32'(n_udr - u0), 32'(eu));
    chk({nm, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({nm, "_miso_oe"}, 32'(miso_oe), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    rx_accept(nm);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_miso"}, 32'(miso), 32'd0);
    chk({nm, "_miso_oe"}, 32'(miso_oe), 32'd0);
    chk({nm, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({nm, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({nm, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({nm, "_rx_overrun"}, 32'(rx_overrun), 32'd0);
    chk({nm, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] mo [4];
    logic [7:0] mi [4];
    logic       p_pol, p_pha, p_lsb, p_pre;
    logic [7:0] p_b;
    int         u0, o0, nf;

    mo = '{default: 8'h00};
    repeat (4) @(negedge PCLK);
    reset_checks("rst");
    PRESETn = 1'b1;
    repeat (8) @(negedge PCLK);

    mo[0] = 8'hF0;
    run_case("t1", 1'b0, 1'b1, 1'b1, 1, mo, 1'b1, 8'hA5);
    mo[0] = 8'hC3;
    run_case("t2", 1'b0, 1'b0, 1'b0, 1, mo, 1'b1, 8'h3C);
    mo[0] = 8'h55;
    run_case("t3", 1'b0, 1'b1, 1'b0, 1, mo, 1'b0, 8'h00);

    // two back-to-back frames, second tx byte written mid-frame
    tx_write(8'h81);
    mo[0] = 8'h12;
    mo[1] = 8'h34;
    u0 = n_udr;
    o0 = n_ovr;
    fork
      spi_xfer(1'b1, 1'b1, 1'b0, 2, 8, 1'b0, mo, mi);
      tx_write(8'h7E);
    join
    chk("t4_miso_b0", 32'(mi[0]), 32'h81);
    chk("t4_miso_b1", 32'(mi[1]), 32'h7E);
    chk("t4_rx_data", 32'(rx_data), 32'h34);
    chk("t4_rx_valid", 32'(rx_valid), 32'd1);
    chk("t4_overruns", 32'(n_ovr - o0), 32'd1);
    chk("t4_underruns", 32'(n_udr - u0), 32'd0);

    // reset in the middle of a frame, rx_valid still pending
    tx_write(8'h5A);
    mo[0] = 8'hC7;
    spi_xfer(1'b0, 1'b0, 1'b0, 1, 5, 1'b1, mo, mi);
    chk("t6_busy_mid", 32'(busy), 32'd1);
    chk("t6_oe_mid", 32'(miso_oe), 32'd1);
    tx_write(8'h99);
    chk("t6_tx_full", 32'(tx_ready), 32'd0);
    PRESETn = 1'b0;
    #1;
    reset_checks("t6_rst");
    #(2*T);
    ss = 1'b1;
    #(5*T);
    PRESETn = 1'b1;
    repeat (8) @(negedge PCLK);
    mo[0] = 8'h0F;
    run_case("t6b", 1'b0, 1'b0, 1'b0, 1, mo, 1'b0, 8'h00);

    // abort after three bits, then a full frame
    mo[0] = 8'hE1;
    spi_xfer(1'b0, 1'b1, 1'b1, 1, 3, 1'b0, mo, mi);
    chk("t5_rx_valid", 32'(rx_valid), 32'd0);
    chk("t5_miso_oe", 32'(miso_oe), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    mo[0] = 8'hAA;
    run_case("t5b", 1'b1, 1'b0, 1'b1, 1, mo, 1'b1, 8'h3D);

    for (int k = 0; k < 12; k++) begin
      p_pol = 1'($urandom_range(0, 1));
      p_pha = 1'($urandom_range(0, 1));
      p_lsb = 1'($urandom_range(0, 1));
      p_pre = 1'($urandom_range(0, 1));
      p_b   = 8'($urandom);
      nf    = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) mo[i] = 8'($urandom);
      run_case("rnd", p_pol, p_pha, p_lsb, nf, mo, p_pre, p_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
